// File: rtl/rsc_parity_checker.sv
// Re-encodes received systematic bits with an 8-state RSC and counts parity/tail mismatches.
// One bit pair consumed per cycle; done pulses Ksize+3 edges after frame start; no backpressure.
module rsc_parity_checker (
  input  logic        clk,
  input  logic        aclr_n,
  input  logic        data_ready,
  input  logic        K,
  input  logic        xk,
  input  logic        zk,
  output logic        busy,
  output logic        done,
  output logic [12:0] err_count,
  output logic        tail_err,
  output logic [2:0]  dd
);

  typedef enum logic [1:0] {IDLE, DATA, TAIL, DONE} state_t;

  state_t      state, state_nxt;
  logic        k_big;
  logic [12:0] bit_cnt;
  logic        q0, q1, q2;
  logic        last_data, last_tail;
  logic        s, p, t;
  logic        x_bad, z_bad;
  logic [1:0]  inc;
  logic [13:0] err_sum;
  logic [12:0] err_sat;

  assign dd = {q2, q1, q0};

  always_ff @(posedge clk or negedge aclr_n) begin
    if (!aclr_n) state <= IDLE;
    else         state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    busy      = 1'b0;
    done      = 1'b0;
    last_data = k_big ? (bit_cnt == 13'd6143) : (bit_cnt == 13'd1055);
    last_tail = (bit_cnt == 13'd2);
    case (state)
      IDLE: if (data_ready) state_nxt = DATA;
      DATA: begin
        busy = 1'b1;
        if (last_data) state_nxt = TAIL;
      end
      TAIL: begin
        busy = 1'b1;
        if (last_tail) state_nxt = DONE;
      end
      DONE: begin
        done      = 1'b1;
        state_nxt = IDLE;
      end
      default: state_nxt = IDLE;
    endcase
  end

  // Tail bits drive the feedback to zero, so the trellis drains back to 000.
  always_comb begin
    t     = q1 ^ q2;
    s     = (state == DATA) ? (xk ^ q1 ^ q2) : 1'b0;
    p     = s ^ q0 ^ q2;
    x_bad = (state == TAIL) && (xk != t);
    z_bad = (zk != p);
    inc   = 2'd0;
    if (state == DATA)      inc = {1'b0, z_bad};
    else if (state == TAIL) inc = {1'b0, x_bad} + {1'b0, z_bad};
    err_sum = {1'b0, err_count} + {12'd0, inc};
    err_sat = err_sum[13] ? 13'h1FFF : err_sum[12:0];
  end

  always_ff @(posedge clk or negedge aclr_n) begin
    if (!aclr_n) begin
      k_big     <= 1'b0;
      bit_cnt   <= 13'd0;
      q0        <= 1'b0;
      q1        <= 1'b0;
      q2        <= 1'b0;
      err_count <= 13'd0;
      tail_err  <= 1'b0;
    end else begin
      case (state)
        IDLE: if (data_ready) begin
          k_big     <= K;
          bit_cnt   <= 13'd0;
          q0        <= 1'b0;
          q1        <= 1'b0;
          q2        <= 1'b0;
          err_count <= 13'd0;
          tail_err  <= 1'b0;
        end
        DATA, TAIL: begin
          q0        <= s;
          q1        <= q0;
          q2        <= q1;
          err_count <= err_sat;
          bit_cnt   <= ((state == DATA && last_data) || (state == TAIL && last_tail))
                       ? 13'd0 : bit_cnt + 13'd1;
          if (state == TAIL && (x_bad || z_bad)) tail_err <= 1'b1;
        end
        default: ;
      endcase
    end
  end

endmodule

// File: doc/rsc_parity_checker.md
RSC_PARITY_CHECKER -- requirements
Module: rsc_parity_checker

Interface
REQ-001 SHALL have port clk, input, 1 bit: single clock; all state updates on its rising edge.
REQ-002 SHALL have port aclr_n, input, 1 bit: reset, asynchronous and active-low; clears all state immediately while low.
REQ-003 SHALL have port data_ready, input, 1 bit: one-cycle frame-start pulse from the receive front end.
REQ-004 SHALL have port K, input, 1 bit: block size select, sampled with data_ready; 0 = 1056 bits, 1 = 6144 bits.
REQ-005 SHALL have port xk, input, 1 bit: received systematic bit (data bits, then 3 tail bits).
REQ-006 SHALL have port zk, input, 1 bit: received parity bit, aligned with xk.
REQ-007 SHALL have port busy, output, 1 bit: high while a frame is being checked.
REQ-008 SHALL have port done, output, 1 bit: one-cycle pulse when the frame check completes.
REQ-009 SHALL have port err_count, output, 13 bits: number of mismatching received bits in the last or current frame.
REQ-010 SHALL have port tail_err, output, 1 bit: high if any tail bit mismatched in the last or current frame.
REQ-011 SHALL have port dd, output, 3 bits: debug copy of the local trellis state {q2,q1,q0}.

Function
REQ-012 SHALL implement FSM states IDLE, DATA, TAIL and DONE.
REQ-013 SHALL maintain a local 8-state RSC re-encoder with registers q0, q1, q2, shifting q0<=s, q1<=q0, q2<=q1 on each consumed bit.
REQ-014 SHALL, in DATA, compute feedback s = xk ^ q1 ^ q2 and expected parity p = s ^ q0 ^ q2, and increment err_count when zk != p.
REQ-015 SHALL, in TAIL, compute expected systematic tail bit t = q1 ^ q2 and force s = 0 with expected parity p = q0 ^ q2; err_count increments by 1 for xk != t and by 1 for zk != p (by up to 2 per cycle); tail_err is set on any tail mismatch.
REQ-016 SHALL, in IDLE, on the edge sampling data_ready=1: latch K, clear q0..q2, err_count, tail_err and the bit counter, and enter DATA.
REQ-017 SHALL consume one data bit per edge in DATA for exactly Ksize edges (1056 or 6144), then enter TAIL.
REQ-018 SHALL consume exactly 3 tail bit pairs in TAIL, then enter DONE.
REQ-019 SHALL hold done=1 for exactly one cycle in DONE, then return to IDLE.
REQ-020 SHALL drive busy=1 in DATA and TAIL only, and busy=0 in IDLE and DONE.
REQ-021 SHALL ignore data_ready in DATA, TAIL and DONE; no restart and no counter change.
REQ-022 SHALL hold err_count and tail_err unchanged after DONE until the next accepted data_ready.
REQ-023 SHALL saturate err_count at 8191; the maximum reachable value is 6150, so saturation never occurs in legal use.
REQ-024 SHALL have local state return to 000 after TAIL by construction; dd reads 000 in DONE.

Reset
REQ-025 SHALL, while aclr_n=0, force state IDLE, q0..q2=0, err_count=0, tail_err=0, busy=0, done=0 and dd=000, asynchronously.
REQ-026 SHALL, when aclr_n is asserted mid-frame, abort the frame with no done pulse; a fresh data_ready is required after release.
REQ-027 SHALL not accept data_ready on an edge where aclr_n is low.

Verification
REQ-028 SHALL be verified for an all-zero frame: data_ready with K=0, then 1059 pairs of xk=0/zk=0 -> err_count=0, tail_err=0, done pulses 1059 edges after start, busy high for 1059 cycles.
REQ-029 SHALL be verified for a first data bit of xk=1 from state 000: zk=1 -> no error, dd becomes 001; zk=0 -> err_count=1.
REQ-030 SHALL be verified for a valid encoded K=1 frame from the golden encoder model with one zk flipped at bit 100 -> err_count=1, tail_err=0, done pulses 6147 edges after start.
REQ-031 SHALL be verified for a valid frame with the first tail xk and zk both inverted -> err_count=2, tail_err=1.
REQ-032 SHALL be verified for aclr_n pulsed low at bit 500 -> busy=0, err_count=0 and dd=000 immediately, no done pulse; the next frame checks normally.
REQ-033 SHALL be verified for data_ready re-pulsed at bit 10 of a frame -> ignored, done still occurs at the original edge count.
